core_ctrl: RTL

Multi-cycle sequencer for the RV32I core. It drives the shared datapath (PC, instruction register, register file, ALU operand muxes, ALU decoder and data-memory port) through fetch, decode, execute, memory and writeback phases. It also handshakes with instruction and data memory that have variable latency. The ALU decoder stays combinational on the instruction register; this block only chooses ALU operands and when results are committed.

---
 rtl/core_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb over a shared datapath.
// Latency: 3 cycles (branch), 4 (ALU/jump/store), 5 (load) from FETCH entry, plus memory waits.
// Backpressure: imem_req/dmem_req held until the matching ready; readys outside a request are ignored.
module core_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            branch_taken,
  output logic            imem_req,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            alu_a_sel,
  output logic            alu_b_sel,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic            trap,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  logic   trap_q, trap_d;
  cls_e   dec_cls;

  // Only the opcode field matters here; the rest of the word feeds the datapath.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[XLEN-1:7];

  // Classify the opcode currently sitting in the instruction register.
  always_comb begin
    dec_cls = C_NONE;
    case (instr[6:0])
      7'b0110011: dec_cls = C_OP;
      7'b0010011: dec_cls = C_OPIMM;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      default:    dec_cls = C_NONE;
    endcase
  end

  // State, latched class and sticky trap registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      trap_q  <= trap_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    trap_d  = trap_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_NONE) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
        else if (cls_q == C_BRANCH)              state_d = S_FETCH;
        else                                     state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode; ir_we and the store-completion pc_we follow ready, and lose to reset.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls_q)
        C_OPIMM, C_LOAD, C_STORE, C_JALR, C_LUI: alu_b_sel = 1'b1;
        C_AUIPC, C_JAL: begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end
        default: ;
      endcase
    end
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready & ~rst;
      end
      S_EXEC: begin
        if (cls_q == C_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = {1'b0, branch_taken};
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        pc_we    = (cls_q == C_STORE) & dmem_ready & ~rst;
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        case (cls_q)
          C_LOAD:         wb_sel = 2'd1;
          C_JAL, C_JALR:  wb_sel = 2'd2;
          C_LUI:          wb_sel = 2'd3;
          default:        wb_sel = 2'd0;
        endcase
        case (cls_q)
          C_JAL:   pc_sel = 2'd1;
          C_JALR:  pc_sel = 2'd2;
          default: pc_sel = 2'd0;
        endcase
      end
      default: ;
    endcase
  end

  assign trap  = trap_q;
  assign state = state_q;

endmodule
